// File: rtl/motion_scheduler_if.sv
// Port bundle for motion_scheduler: frame-sync and move requests in, position and status out.
// Define MOTION_SCHEDULER_BOUNCE_EN at build time for bouncing auto motion (default: wrap-around).
interface motion_scheduler_if;
  // Handshake: a VGA_VS rising edge asks for one frame update. There is no
  // backpressure. frame_done pulses for one cycle in the same cycle posx/posy
  // take their new values. A rise that arrives while busy is dropped and
  // latched into overrun.
  logic        VGA_VS;
  logic        req_left;
  logic        req_right;
  logic        req_up;
  logic        req_down;
  logic        auto_en;
  logic [3:0]  speed;
  logic [10:0] posx;
  logic [10:0] posy;
  logic        frame_done;
  logic        busy;
  logic        hit_x;
  logic        hit_y;
  logic        overrun;
  logic [1:0]  state_dbg;

  modport master (
    output VGA_VS, req_left, req_right, req_up, req_down, auto_en, speed,
    input  posx, posy, frame_done, busy, hit_x, hit_y, overrun, state_dbg
  );

  modport slave (
    input  VGA_VS, req_left, req_right, req_up, req_down, auto_en, speed,
    output posx, posy, frame_done, busy, hit_x, hit_y, overrun, state_dbg
  );
endinterface

// File: rtl/motion_scheduler.sv
// Per-frame rectangle position scheduler with manual/auto motion and a 3-cycle atomic commit.
// MOTION_SCHEDULER_BOUNCE_EN selects bouncing auto motion; when it is undefined, auto motion wraps.
module motion_scheduler #(
  parameter int H         = 1280,
  parameter int V         = 1024,
  parameter int LARGHEZZA = 400,
  parameter int ALTEZZA   = 300
) (
  input logic             VGA_CLK,
  input logic             reset,
  motion_scheduler_if.slave bus
);
  localparam logic signed [11:0] XMAX   = 12'(H - LARGHEZZA);
  localparam logic signed [11:0] YMAX   = 12'(V - ALTEZZA);
  localparam logic [10:0]        X_HOME = 11'((H - LARGHEZZA) / 2);
  localparam logic [10:0]        Y_HOME = 11'((V - ALTEZZA) / 2);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  typedef struct packed {
    logic [10:0] pos;
    logic        dir;
    logic        hit;
  } axis_t;

  state_t      state;
  logic        vs_d;
  logic        tick;
  axis_t       nx, ny;
  logic [10:0] posx_r, posy_r;
  logic        dirx, diry;
  logic        frame_done_r, busy_r, hit_x_r, hit_y_r, overrun_r;

  assign tick = bus.VGA_VS & ~vs_d;

  // One axis step: dir=1 means increasing. Opposing manual requests freeze the axis.
  function automatic axis_t step_axis(input logic [10:0] pos, input logic dec_req,
                                      input logic inc_req, input logic auto,
                                      input logic dir, input logic [3:0] spd,
                                      input logic signed [11:0] lim);
    axis_t r;
    logic signed [11:0] p, s, sum;
    p     = $signed({1'b0, pos});
    s     = $signed({8'b0, spd});
    sum   = p;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dec_req && inc_req) begin
      r.pos = pos;
    end else if (dec_req || inc_req) begin
      sum = inc_req ? p + s : p - s;
      if (sum < 12'sd0)    r.pos = 11'd0;
      else if (sum > lim)  r.pos = lim[10:0];
      else                 r.pos = sum[10:0];
    end else if (auto && spd != 4'd0) begin
      sum = dir ? p + s : p - s;
`ifdef MOTION_SCHEDULER_BOUNCE_EN
      if (dir && sum >= lim) begin
        r.pos = lim[10:0]; r.dir = 1'b0; r.hit = 1'b1;
      end else if (!dir && sum <= 12'sd0) begin
        r.pos = 11'd0;     r.dir = 1'b1; r.hit = 1'b1;
      end else begin
        r.pos = sum[10:0];
      end
`else
      if (sum > lim) begin
        r.pos = 11'd0;     r.hit = 1'b1;
      end else if (sum < 12'sd0) begin
        r.pos = lim[10:0]; r.hit = 1'b1;
      end else begin
        r.pos = sum[10:0];
      end
`endif
    end
    return r;
  endfunction

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      state        <= IDLE;
      vs_d         <= 1'b1;
      posx_r       <= X_HOME;
      posy_r       <= Y_HOME;
      dirx         <= 1'b1;
      diry         <= 1'b1;
      nx           <= '0;
      ny           <= '0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      hit_x_r      <= 1'b0;
      hit_y_r      <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      vs_d         <= bus.VGA_VS;
      frame_done_r <= 1'b0;
      hit_x_r      <= 1'b0;
      hit_y_r      <= 1'b0;
      if (tick && state != IDLE) overrun_r <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            state  <= CALC_X;
            busy_r <= 1'b1;
          end
        end
        CALC_X: begin
          nx    <= step_axis(posx_r, bus.req_left, bus.req_right, bus.auto_en,
                             dirx, bus.speed, XMAX);
          state <= CALC_Y;
        end
        CALC_Y: begin
          ny    <= step_axis(posy_r, bus.req_up, bus.req_down, bus.auto_en,
                             diry, bus.speed, YMAX);
          state <= COMMIT;
        end
        COMMIT: begin
          // Position, direction and hit flags all change together here.
          posx_r       <= nx.pos;
          posy_r       <= ny.pos;
          dirx         <= nx.dir;
          diry         <= ny.dir;
          hit_x_r      <= nx.hit;
          hit_y_r      <= ny.hit;
          frame_done_r <= 1'b1;
          busy_r       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.posx       = posx_r;
  assign bus.posy       = posy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.busy       = busy_r;
  assign bus.hit_x      = hit_x_r;
  assign bus.hit_y      = hit_y_r;
  assign bus.overrun    = overrun_r;
  assign bus.state_dbg  = state;
endmodule
